// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V writeback pipeline.
// Holds the writeback select enum, load funct3 codes and stage control bundle.
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wbsel_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // wbsel kept as raw bits so the reserved code 11 stays representable
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwen;
    logic [1:0] wbsel;
    logic [2:0] funct3;
  } wb_ctrl_t;

endpackage

// File: rtl/riscv_load_align.sv
// Load data alignment: selects byte/halfword by offset and extends it.
// Purely combinational; word loads and unknown codes pass through.
module riscv_load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_off,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    unique case (i_off)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
    endcase
    w_half = i_off[1] ? i_rdata[31:16]
                      : i_rdata[15:0];
  end

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:  o_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU: o_data = {{(XLEN-16){1'b0}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/riscv_wb_pipe.sv
// Writeback pipeline EX -> MEM -> WB driving the regfile write port.
// Optional same-cycle bypass flags enabled by RISCV_WB_BYPASS_EN.
module riscv_wb_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [4:0]      rd_i,
  input  logic            regwen_i,
  input  logic [1:0]      wbsel_i,
  input  logic [2:0]      funct3_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
`ifdef RISCV_WB_BYPASS_EN
  input  logic [4:0]      AddrA_i,
  input  logic [4:0]      AddrB_i,
  output logic            bypA_o,
  output logic            bypB_o,
`endif
  output logic [4:0]      AddrD_o,
  output logic [XLEN-1:0] DataD_o,
  output logic            RegWEn_o
);

  wb_ctrl_t        r_ex_ctrl;
  logic [PC_W-1:0] r_ex_pc4;
  wb_ctrl_t        r_mem_ctrl;
  logic [PC_W-1:0] r_mem_pc4;
  logic [XLEN-1:0] r_mem_alu;
  wb_ctrl_t        r_wb_ctrl;
  logic [PC_W-1:0] r_wb_pc4;
  logic [XLEN-1:0] r_wb_alu;
  logic [XLEN-1:0] r_wb_load;

  wb_ctrl_t        w_dec_ctrl;
  logic [PC_W-1:0] w_dec_pc4;
  wb_ctrl_t        w_ex_nxt;
  wb_ctrl_t        w_mem_nxt;
  logic [XLEN-1:0] w_load;
  logic            w_unused;

  always_comb begin
    w_dec_ctrl.valid  = 1'b1;
    w_dec_ctrl.rd     = rd_i;
    w_dec_ctrl.regwen = regwen_i;
    w_dec_ctrl.wbsel  = wbsel_i;
    w_dec_ctrl.funct3 = funct3_i;
    w_dec_pc4         = pc_i + PC_W'(4);
  end

  // flush overrides stall for EX and MEM; WB only obeys stall
  always_comb begin
    w_ex_nxt = r_ex_ctrl;
    if (!stall_i)
      w_ex_nxt = w_dec_ctrl;
    if (flush_i)
      w_ex_nxt.valid = 1'b0;
    w_mem_nxt = r_mem_ctrl;
    if (!stall_i)
      w_mem_nxt = r_ex_ctrl;
    if (flush_i)
      w_mem_nxt.valid = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ex_ctrl <= '0;
      r_ex_pc4  <= '0;
    end else begin
      r_ex_ctrl <= w_ex_nxt;
      if (!stall_i)
        r_ex_pc4 <= w_dec_pc4;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem_ctrl <= '0;
      r_mem_pc4  <= '0;
      r_mem_alu  <= '0;
    end else begin
      r_mem_ctrl <= w_mem_nxt;
      if (!stall_i) begin
        r_mem_pc4 <= r_ex_pc4;
        r_mem_alu <= alu_result_i;
      end
    end
  end

  riscv_load_align #(
    .XLEN(XLEN)
  ) u_align (
    .i_rdata (dmem_rdata_i),
    .i_off   (r_mem_alu[1:0]),
    .i_funct3(r_mem_ctrl.funct3),
    .o_data  (w_load)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wb_ctrl <= '0;
      r_wb_pc4  <= '0;
      r_wb_alu  <= '0;
      r_wb_load <= '0;
    end else if (!stall_i) begin
      r_wb_ctrl <= r_mem_ctrl;
      r_wb_pc4  <= r_mem_pc4;
      r_wb_alu  <= r_mem_alu;
      r_wb_load <= w_load;
    end
  end

  always_comb begin
    DataD_o = r_wb_alu;
    case (r_wb_ctrl.wbsel)
      WB_MEM:  DataD_o = r_wb_load;
      WB_PC4:  DataD_o = XLEN'(r_wb_pc4);
      default: DataD_o = r_wb_alu;
    endcase
  end

  assign AddrD_o  = r_wb_ctrl.rd;
  assign RegWEn_o = r_wb_ctrl.valid
                  & r_wb_ctrl.regwen
                  & (r_wb_ctrl.rd != 5'd0);
  assign w_unused = ^r_wb_ctrl.funct3;

`ifdef RISCV_WB_BYPASS_EN
  assign bypA_o = RegWEn_o & (AddrA_i == AddrD_o);
  assign bypB_o = RegWEn_o & (AddrB_i == AddrD_o);
`endif

endmodule

// File: tb/tb_riscv_wb_pipe.sv
// Scoreboard bench for riscv_wb_pipe: directed plus random traffic.
// Bypass flags are checked when RISCV_WB_BYPASS_EN is defined.
`timescale 1ns/1ps
module tb_riscv_wb_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b1;
  logic        flush = 1'b0;
  logic [4:0]  rd_i = '0;
  logic        regwen_i = 1'b0;
  logic [1:0]  wbsel_i = '0;
  logic [2:0]  f3_i = '0;
  logic [31:0] pc_i = '0;
  logic [31:0] alu_i = '0;
  logic [31:0] dmem_i = '0;
  logic [4:0]  addr_a = '0;
  logic [4:0]  addr_b = '0;
  logic        byp_a;
  logic        byp_b;
  logic [4:0]  addr_d;
  logic [31:0] data_d;
  logic        wen;

  always #5 clk = ~clk;

  riscv_wb_pipe #(.XLEN(32), .PC_W(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .stall_i     (stall),
    .flush_i     (flush),
    .rd_i        (rd_i),
    .regwen_i    (regwen_i),
    .wbsel_i     (wbsel_i),
    .funct3_i    (f3_i),
    .pc_i        (pc_i),
    .alu_result_i(alu_i),
    .dmem_rdata_i(dmem_i),
`ifdef RISCV_WB_BYPASS_EN
    .AddrA_i     (addr_a),
    .AddrB_i     (addr_b),
    .bypA_o      (byp_a),
    .bypB_o      (byp_b),
`endif
    .AddrD_o     (addr_d),
    .DataD_o     (data_d),
    .RegWEn_o    (wen)
  );

`ifndef RISCV_WB_BYPASS_EN
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic        regwen;
    logic [1:0]  wbsel;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] dmem;
    bit          alive;
  } ins_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  ins_t recs[int];
  wr_t  q[$];
  int   T = 0;
  bit   prev_stall = 1'b1;
  bit   last_wen = 1'b0;
  wr_t  last;
  int   n_chk = 0;
  int   n_pass = 0;
  int   sel_a = -1;
  int   sel_b = -1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] ref_wb(input ins_t r);
    logic [31:0] sh;
    int off;
    off = int'(r.alu[1:0]);
    if (r.wbsel == 2'b10) return r.pc + 32'd4;
    if (r.wbsel != 2'b01) return r.alu;
    case (r.f3)
      3'b000: begin sh = r.dmem >> (8 * off);
        return 32'($signed(sh[7:0])); end
      3'b100: begin sh = r.dmem >> (8 * off);
        return 32'(sh[7:0]); end
      3'b001: begin sh = r.dmem >> (16 * (off / 2));
        return 32'($signed(sh[15:0])); end
      3'b101: begin sh = r.dmem >> (16 * (off / 2));
        return 32'(sh[15:0]); end
      default: return r.dmem;
    endcase
  endfunction

  function automatic ins_t mk(input logic [4:0] rd, input logic we,
                              input logic [1:0] ws, input logic [2:0] f3,
                              input logic [31:0] pc, input logic [31:0] alu,
                              input logic [31:0] dm);
    ins_t r;
    r.rd = rd; r.regwen = we; r.wbsel = ws; r.f3 = f3;
    r.pc = pc; r.alu = alu; r.dmem = dm; r.alive = 1'b1;
    return r;
  endfunction

  function automatic ins_t mk_rand();
    logic [31:0] pc;
    pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & ~32'h3);
    return mk(5'($urandom_range(0, 7)), $urandom_range(0, 9) != 0,
              2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              pc, $urandom(), $urandom());
  endfunction

  task automatic step(input bit st, input bit fl, input ins_t d);
    ins_t r;
    @(negedge clk); #1;
    stall = st; flush = fl;
    rd_i = d.rd; regwen_i = d.regwen; wbsel_i = d.wbsel;
    f3_i = d.f3; pc_i = d.pc;
    alu_i  = recs.exists(T - 1) ? recs[T - 1].alu  : $urandom();
    dmem_i = recs.exists(T - 2) ? recs[T - 2].dmem : $urandom();
    addr_a = (sel_a >= 0) ? 5'(sel_a) : 5'($urandom_range(0, 7));
    addr_b = (sel_b >= 0) ? 5'(sel_b) : 5'($urandom_range(0, 7));
    @(posedge clk);
    prev_stall = st;
    if (!st) begin
      d.alive = !fl;
      recs[T] = d;
      if (fl && recs.exists(T - 1)) recs[T - 1].alive = 1'b0;
      T++;
      if (recs.exists(T - 3)) begin
        r = recs[T - 3];
        if (r.alive && r.regwen && r.rd != 5'd0)
          q.push_back('{rd: r.rd, data: ref_wb(r)});
      end
    end else if (fl) begin
      if (recs.exists(T - 1)) recs[T - 1].alive = 1'b0;
      if (recs.exists(T - 2)) recs[T - 2].alive = 1'b0;
    end
  endtask

  task automatic mid_reset();
    @(negedge clk); #2;
    rst = 1'b1; stall = 1'b1; flush = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(addr_d), 32'd0);
    chk("mid_rst_data", data_d, 32'd0);
    chk("mid_rst_wen", 32'(wen), 32'd0);
    recs.delete(); q.delete();
    T = 0; last_wen = 1'b0; prev_stall = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    bit  ew;
    wr_t e;
    ew = 1'b0;
    e = '{rd: 5'd0, data: 32'd0};
    if (rst) begin
      chk("rst_addr", 32'(addr_d), 32'd0);
      chk("rst_data", data_d, 32'd0);
      chk("rst_wen", 32'(wen), 32'd0);
    end else begin
      if (prev_stall) begin
        ew = last_wen; e = last;
        chk("hold_wen", 32'(wen), 32'(ew));
        if (ew) begin
          chk("hold_addr", 32'(addr_d), 32'(e.rd));
          chk("hold_data", data_d, e.data);
        end
      end else begin
        ew = (q.size() > 0);
        chk("wen", 32'(wen), 32'(ew));
        if (ew) begin
          e = q.pop_front();
          chk("addr", 32'(addr_d), 32'(e.rd));
          chk("data", data_d, e.data);
          last = e;
        end
        last_wen = ew;
      end
`ifdef RISCV_WB_BYPASS_EN
      chk("bypA", 32'(byp_a), 32'(ew && addr_a == e.rd));
      chk("bypB", 32'(byp_b), 32'(ew && addr_b == e.rd));
`endif
    end
  end

  initial begin
    ins_t z;
    z = mk(5'd0, 1'b0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    step(0, 0, mk(5'd3, 1, 2'b01, 3'b000, 0, 32'h1000, 32'h8070_F0A1));
    step(0, 0, mk(5'd4, 1, 2'b01, 3'b100, 0, 32'h1003, 32'h8070_F0A1));
    step(0, 0, mk(5'd6, 1, 2'b01, 3'b001, 0, 32'h1002, 32'h8070_F0A1));
    step(0, 0, mk(5'd7, 1, 2'b01, 3'b101, 0, 32'h1001, 32'h8070_F0A1));
    step(0, 0, mk(5'd2, 1, 2'b01, 3'b010, 0, 32'h1003, 32'h8070_F0A1));
    step(0, 0, mk(5'd0, 1, 2'b00, 3'b000, 0, 32'd18, 0));
    step(0, 0, mk(5'd5, 1, 2'b00, 3'b000, 0, 32'd18, 0));
    step(0, 0, mk(5'd1, 1, 2'b10, 3'b000, 32'h100, 32'h55, 0));
    step(0, 0, mk(5'd1, 1, 2'b10, 3'b000, 32'h100, 32'h66, 0));
    step(0, 1, mk(5'd2, 1, 2'b00, 3'b000, 0, 32'h77, 0));
    step(0, 0, mk(5'd9, 1, 2'b00, 3'b000, 0, 32'h99, 0));
    step(1, 0, z);
    step(1, 0, z);
    step(0, 0, mk(5'd10, 1, 2'b00, 3'b000, 0, 32'hA0, 0));
    step(0, 0, mk(5'd11, 1, 2'b11, 3'b000, 32'h40, 32'hB0, 0));
    step(0, 0, mk(5'd12, 1, 2'b10, 3'b000, 32'hFFFF_FFFC, 0, 0));
    step(1, 1, z);
    sel_a = 8; sel_b = 0;
    step(0, 0, mk(5'd8, 1, 2'b00, 3'b000, 0, 32'h88, 0));
    step(0, 0, mk(5'd0, 1, 2'b00, 3'b000, 0, 32'h11, 0));
    repeat (4) step(0, 0, z);
    sel_a = -1; sel_b = -1;

    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      step($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8,
           mk_rand());
    end
    repeat (5) step(0, 0, z);
    @(negedge clk); #1;
    chk("drain_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/riscv_wb_pipe.md
# riscv_wb_pipe

Writeback pipeline for the RISC-V core, directly upstream of `riscv_regfile`. It carries each instruction's destination register and writeback controls from decode through EX and MEM, and captures the ALU result and data-memory read data. It aligns and sign-extends loads, then drives the regfile write port (`AddrD`, `DataD`, `RegWEn`) exactly three cycles after decode.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `PC_W`, 32, program counter width

Ports:
- `clk_i` in 1: clock, rising edge
- `rst_i` in 1: asynchronous, active-high reset
- `stall_i` in 1: freezes every stage register
- `flush_i` in 1: kills the instruction entering EX and the instruction in EX
- `rd_i` in 5: decode-stage destination register
- `regwen_i` in 1: decode-stage write enable
- `wbsel_i` in 2: writeback source; 00 = ALU, 01 = MEM, 10 = PC+4, 11 = reserved (treated as ALU)
- `funct3_i` in 3: load type
- `pc_i` in PC_W: decode-stage PC
- `alu_result_i` in XLEN: valid during EX
- `dmem_rdata_i` in XLEN: word-aligned read data, valid during MEM
- `AddrD_o` out 5: regfile write address
- `DataD_o` out XLEN: regfile write data
- `RegWEn_o` out 1: regfile write enable

## Operation
- There are three stage registers: EX, MEM and WB. Each holds `valid`, `rd`, `regwen`, `wbsel`, `funct3` and `pc+4`.
- EX captures decode inputs. MEM additionally captures `alu_result_i`. WB additionally captures the aligned load result and the ALU result.
- Load alignment uses the low 2 bits of the MEM-stage ALU result as the byte offset:
  - LB (000): selects byte[off] and sign-extends it.
  - LBU (100): selects byte[off] and zero-extends it.
  - LH (001): selects halfword[off[1]] and sign-extends it; off[0] is ignored.
  - LHU (101): selects halfword[off[1]] and zero-extends it; off[0] is ignored.
  - LW (010) and all other codes: passes the word through; off is ignored.
- `DataD_o` is the MEM result if wbsel = 01, pc+4 if wbsel = 10, otherwise the ALU result. pc+4 is computed modulo 2^PC_W and zero-extended to XLEN.
- `RegWEn_o` = WB.valid & WB.regwen & (WB.rd != 0). This means x0 is never written.
- `AddrD_o` = WB.rd, whatever the value of `RegWEn_o`.

## Timing
- Reset: all stage `valid` = 0 and all fields = 0. `AddrD_o` = 0, `DataD_o` = 0, `RegWEn_o` = 0.
- Reset is asynchronous. Asserting it mid-operation discards all in-flight instructions on the same cycle. No write is issued until three cycles after the first post-reset decode.
- Latency: an instruction presented at decode in cycle n drives the write port during cycle n+3. The regfile commits it on the rising edge that ends cycle n+3.
- Throughput: one instruction per cycle.
- `stall_i` = 1 holds all stages, including WB, so the write port repeats the same values. Repeating a write is idempotent.
- `flush_i` = 1 loads EX with valid = 0 and clears MEM.valid on the next edge. WB is unaffected.
- `stall_i` and `flush_i` both high: flush wins for EX and MEM; WB holds.

## Configuration
- `RISCV_WB_BYPASS_EN`: adds ports `AddrA_i` in 5, `AddrB_i` in 5, `bypA_o` out 1, `bypB_o` out 1.
  - `bypX_o` = `RegWEn_o` & (`AddrX_i` == `AddrD_o`).
  - The ports tell the decode mux to take `DataD_o` instead of the regfile read for a same-cycle write/read.
- Without the macro, the ports are absent. Same-cycle read-after-write returns the old register value.

## Structure
- Shared package `riscv_pkg`:
  - `wbsel_t` enum: `WB_ALU`, `WB_MEM`, `WB_PC4`.
  - funct3 load constants: `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
  - stage struct `wb_ctrl_t`.
- One combinational sub-module, `riscv_load_align` (inputs: rdata, off, funct3; output: aligned value).

## Test plan
- Load alignment and sign extension: dmem = 0x8070_F0A1.
  - LB off 0 -> 0xFFFF_FFA1.
  - LBU off 3 -> 0x0000_0080.
  - LH off 2 -> 0xFFFF_8070.
  - LHU off 1 -> 0x0000_F0A1.
- x0 suppression and plain writeback: rd = 0, regwen = 1 -> `RegWEn_o` stays 0 at n+3. rd = 5 with ALU source, result 18 -> n+3: AddrD = 5, DataD = 18, RegWEn = 1. The regfile reads back 18 at n+4.
- PC+4 and flush: JAL with pc = 0x0000_0100, rd = 1 -> DataD = 0x104 at n+3. A flush in cycle n+1 kills it, so `RegWEn_o` = 0 at n+3.
- Stall: a 2-cycle stall in cycle n+1 moves the write to n+5 with the same data. No duplicate or lost writes across back-to-back instructions.
- Reset mid-operation: reset asserted with 3 instructions in flight -> outputs are 0 immediately and no writes occur until a new decode + 3 cycles.
- Bypass (macro on): `AddrA_i` = 8 while WB writes x8 -> `bypA_o` = 1. With `AddrB_i` = 0 and a write to x0 attempted -> `bypB_o` = 0.
